proc_param: RTL and testbench

- Parametrised multicycle processor; successor to the team's 16-bit bus processor.
- Data width is generic. Adds condition flags, conditional branches and an external Done strobe.
- Sits between synchronous memory/IO (DIN/DOUT/ADDR/W) and the top-level system. Eight registers r0–r7, where r7 is the pc.

---
 rtl/proc_param.sv | 197 +++++++++++++++++++
 tb/tb_proc_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_param.sv
// proc_param: parametrised multicycle processor, r0-r7 with r7 as pc, {N,Z,C} flags, conditional branches.
// Define PROC_SHIFT_EN to turn opcode 111 into lsl/lsr/asr/ror; otherwise 111 is a NOP.

module proc_param #(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] DOUT,
  output logic [AW-1:0] ADDR,
  output logic          W,
  output logic          Done,
  output logic [2:0]    Flags,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
  } state_t;

  localparam logic [2:0] OP_MV    = 3'b000;
  localparam logic [2:0] OP_MVT_B = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_LD    = 3'b100;
  localparam logic [2:0] OP_ST    = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_SHIFT = 3'b111;

`ifdef PROC_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  state_t        state_q;
  logic [DW-1:0] r_q [8];
  logic [DW-1:0] a_q, g_q, dout_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   ir_q;
  logic          w_q;
  logic [2:0]    flags_q;

  logic [2:0]    iii, rx, ry;
  logic          m;
  logic [DW-1:0] imm, mvt_data, opb, alu_res;
  logic [DW:0]   sum, diff;
  logic          alu_c, cond_true, is_alu, done_w;

`ifdef PROC_SHIFT_EN
  int            sh_n;
  logic [DW:0]   wide_l, wide_r, wide_a;
  logic [DW-1:0] rot;
`endif

  always_comb begin
    iii      = ir_q[15:13];
    m        = ir_q[12];
    rx       = ir_q[11:9];
    ry       = ir_q[2:0];
    imm      = {{(DW-9){ir_q[8]}}, ir_q[8:0]};
    mvt_data = {ir_q[7:0], {(DW-8){1'b0}}};
    opb      = m ? imm : r_q[ry];
    sum      = {1'b0, a_q} + {1'b0, opb};
    diff     = {1'b0, a_q} - {1'b0, opb};

    // flags_q = {N, Z, C}
    case (rx)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flags_q[1];
      3'b010:  cond_true = ~flags_q[1];
      3'b011:  cond_true = ~flags_q[0];
      3'b100:  cond_true = flags_q[0];
      3'b101:  cond_true = ~flags_q[2];
      3'b110:  cond_true = flags_q[2];
      default: cond_true = 1'b0;
    endcase

    // Default result is the branch target, which G also takes in T4.
    alu_res = a_q + imm;
    alu_c   = 1'b0;
    is_alu  = 1'b0;
    case (iii)
      OP_ADD: begin alu_res = sum[DW-1:0];  alu_c = sum[DW];   is_alu = 1'b1; end
      OP_SUB: begin alu_res = diff[DW-1:0]; alu_c = ~diff[DW]; is_alu = 1'b1; end
      OP_AND: begin alu_res = a_q & opb;    alu_c = 1'b0;      is_alu = 1'b1; end
      default: ;
    endcase

`ifdef PROC_SHIFT_EN
    // Guard bit below/above A captures the last bit shifted out; it stays 0 for amount 0.
    sh_n   = int'(m ? {1'b0, ir_q[3:0]} : r_q[ry][4:0]) % DW;
    wide_l = {1'b0, a_q} << sh_n;
    wide_r = {a_q, 1'b0} >> sh_n;
    wide_a = $unsigned($signed({a_q, 1'b0}) >>> sh_n);
    rot    = (a_q >> sh_n) | (a_q << (DW - sh_n));
    if (iii == OP_SHIFT) begin
      is_alu = 1'b1;
      case (ir_q[6:5])
        2'b00:   begin alu_res = wide_l[DW-1:0]; alu_c = wide_l[DW]; end
        2'b01:   begin alu_res = wide_r[DW:1];   alu_c = wide_r[0];  end
        2'b10:   begin alu_res = wide_a[DW:1];   alu_c = wide_a[0];  end
        default: begin alu_res = rot;            alu_c = wide_r[0];  end
      endcase
    end
`endif

    done_w = 1'b0;
    case (state_q)
      T3: begin
        case (iii)
          OP_MV:    done_w = 1'b1;
          OP_MVT_B: done_w = m | ~cond_true;
          OP_SHIFT: done_w = ~SHIFT_EN;
          default:  done_w = 1'b0;
        endcase
      end
      T4:      done_w = (iii == OP_ST);
      T5:      done_w = 1'b1;
      default: done_w = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= T0;
      for (int i = 0; i < 7; i++) r_q[i] <= '0;
      r_q[7]  <= RESET_PC;
      a_q     <= '0;
      g_q     <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      w_q     <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      w_q <= 1'b0;
      case (state_q)
        T0: begin
          if (Run) begin
            addr_q  <= r_q[7][AW-1:0];
            r_q[7]  <= r_q[7] + DW'(1);
            state_q <= T1;
          end
        end
        T1: state_q <= T2;
        T2: begin
          ir_q    <= DIN[15:0];
          state_q <= T3;
        end
        T3: begin
          case (iii)
            OP_MV: r_q[rx] <= m ? imm : r_q[ry];
            OP_MVT_B: begin
              if (m) r_q[rx] <= mvt_data;
              else if (cond_true) a_q <= r_q[7];
            end
            OP_ADD, OP_SUB, OP_AND: a_q <= r_q[rx];
            OP_SHIFT: if (SHIFT_EN) a_q <= r_q[rx];
            OP_LD, OP_ST: addr_q <= r_q[ry][AW-1:0];
            default: ;
          endcase
          state_q <= done_w ? T0 : T4;
        end
        T4: begin
          if (iii == OP_ST) begin
            dout_q <= r_q[rx];
            w_q    <= 1'b1;
          end else begin
            g_q <= alu_res;
            if (is_alu) flags_q <= {alu_res[DW-1], (alu_res == '0), alu_c};
          end
          state_q <= done_w ? T0 : T5;
        end
        T5: begin
          if (iii == OP_LD)         r_q[rx] <= DIN;
          else if (iii == OP_MVT_B) r_q[7]  <= g_q;
          else                      r_q[rx] <= g_q;
          state_q <= T0;
        end
        default: state_q <= T0;
      endcase
    end
  end

  assign DOUT        = dout_q;
  assign ADDR        = addr_q;
  assign W           = w_q;
  assign Done        = done_w;
  assign Flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param: a 16-bit core (pc reset 0x10) and a 32-bit core, each with a 1-cycle memory.
// Per-instruction Done cycle, FSM state and pc are recorded by run_prog and checked by the scenario tasks.

module tb_proc_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn16, run16, w16, done16;
  logic [15:0] din16, dout16, addr16;
  logic [2:0]  flags16, st16;
  logic        rstn32, run32, w32, done32;
  logic [31:0] din32, dout32;
  logic [15:0] addr32;
  logic [2:0]  flags32, st32;

  logic [15:0] mem16 [256];
  logic [31:0] mem32 [256];

  int          errors = 0;
  int          checks = 0;
  bit          timed_out;
  int          done_cyc [$];
  int          done_st [$];
  logic [31:0] done_pc [$];
  int          w_cnt, extra_done;
  logic [31:0] w_dout;
  logic [15:0] w_addr;

  proc_param #(.DW(16), .AW(16), .RESET_PC(16'h0010)) u16 (
    .Clock(clk), .Resetn(rstn16), .Run(run16), .DIN(din16), .DOUT(dout16), .ADDR(addr16),
    .W(w16), .Done(done16), .Flags(flags16), .dbg_state_o(st16)
  );

  proc_param #(.DW(32), .AW(16), .RESET_PC(32'h0)) u32 (
    .Clock(clk), .Resetn(rstn32), .Run(run32), .DIN(din32), .DOUT(dout32), .ADDR(addr32),
    .W(w32), .Done(done32), .Flags(flags32), .dbg_state_o(st32)
  );

  always @(posedge clk) begin
    din16 <= mem16[addr16[7:0]];
    if (w16) mem16[addr16[7:0]] <= dout16;
    din32 <= mem32[addr32[7:0]];
    if (w32) mem32[addr32[7:0]] <= dout32;
  end

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      mem16[i] = '0;
      mem32[i] = '0;
    end
  endtask

  task automatic reset_dut(input bit sel);
    run16 = 1'b0;
    run32 = 1'b0;
    if (sel) rstn32 = 1'b0; else rstn16 = 1'b0;
    repeat (2) @(negedge clk);
    rstn16 = 1'b1;
    rstn32 = 1'b1;
  endtask

  // Cycle 1 is the T0 cycle in which Run is first seen; Run drops once n Done pulses arrive.
  task automatic run_prog(input bit sel, input int n, input int budget);
    int c, seen;
    c = 0;
    seen = 0;
    done_cyc.delete(); done_st.delete(); done_pc.delete();
    w_cnt = 0;
    extra_done = 0;
    if (sel) run32 = 1'b1; else run16 = 1'b1;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if ((sel ? w32 : w16) === 1'b1) begin
        if (w_cnt == 0) begin
          w_dout = sel ? dout32 : {16'h0, dout16};
          w_addr = sel ? addr32 : addr16;
        end
        w_cnt++;
      end
      if ((sel ? done32 : done16) === 1'b1) begin
        done_cyc.push_back(c + 1);
        done_st.push_back(int'(sel ? st32 : st16));
        done_pc.push_back(sel ? u32.r_q[7] : {16'h0, u16.r_q[7]});
        seen++;
        if (seen == n) begin
          run16 = 1'b0;
          run32 = 1'b0;
        end
      end
    end
    run16 = 1'b0;
    run32 = 1'b0;
    timed_out = (seen < n);
    repeat (3) begin
      @(negedge clk);
      if ((sel ? w32 : w16) === 1'b1) w_cnt++;
      if ((sel ? done32 : done16) !== 1'b0) extra_done++;
    end
  endtask

  task automatic test_reset();
    clear_mems();
    reset_dut(1'b0);
    checks++; if (u16.r_q[7] !== 16'h0010) begin errors++; $display("FAIL reset_pc: got %h want 0010", u16.r_q[7]); end
    checks++; if (w16 !== 1'b0) begin errors++; $display("FAIL reset_w: got %b want 0", w16); end
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done16); end
    checks++; if (flags16 !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", flags16); end
    checks++; if (st16 !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st16); end
    checks++; if (addr16 !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", addr16); end
    checks++; if (dout16 !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout16); end
    repeat (5) @(negedge clk);
    checks++; if (addr16 !== 16'h0000) begin errors++; $display("FAIL idle_addr: got %h want 0000", addr16); end
    checks++; if (u16.r_q[7] !== 16'h0010) begin errors++; $display("FAIL idle_pc: got %h want 0010", u16.r_q[7]); end
    checks++; if (st16 !== 3'd0) begin errors++; $display("FAIL idle_state: got %0d want 0", st16); end
  endtask

  task automatic test_mv_add();
    clear_mems();
    mem16[16] = 16'h11FF;  // mv  r0,#-1
    mem16[17] = 16'h5001;  // add r0,#1
    reset_dut(1'b0);
    run_prog(1'b0, 2, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL mvadd_timeout: got %0d done pulses want 2", done_cyc.size()); end
    checks++; if (done_cyc.size() != 2) begin errors++; $display("FAIL mvadd_pulses: got %0d want 2", done_cyc.size()); end
    checks++; if (done_cyc[0] != 4) begin errors++; $display("FAIL mvadd_done1_cycle: got %0d want 4", done_cyc[0]); end
    checks++; if (done_cyc[1] != 10) begin errors++; $display("FAIL mvadd_done2_cycle: got %0d want 10", done_cyc[1]); end
    checks++; if (u16.r_q[0] !== 16'h0000) begin errors++; $display("FAIL mvadd_r0: got %h want 0000", u16.r_q[0]); end
    checks++; if (flags16 !== 3'b011) begin errors++; $display("FAIL mvadd_flags: got %b want 011", flags16); end
    checks++; if (u16.r_q[7] !== 16'h0012) begin errors++; $display("FAIL mvadd_pc: got %h want 0012", u16.r_q[7]); end
    checks++; if (extra_done != 0) begin errors++; $display("FAIL mvadd_idle_done: got %0d want 0", extra_done); end
  endtask

  task automatic test_branch();
    clear_mems();
    mem16[16] = 16'h1205;  // mv  r1,#5
    mem16[17] = 16'h7205;  // sub r1,#5
    mem16[18] = 16'h25FE;  // bne #-2
    mem16[19] = 16'h2203;  // beq #+3
    reset_dut(1'b0);
    run_prog(1'b0, 4, 80);
    checks++; if (timed_out) begin errors++; $display("FAIL br_timeout: got %0d done pulses want 4", done_cyc.size()); end
    checks++; if (done_st[2] != 3) begin errors++; $display("FAIL br_bne_done_state: got %0d want 3", done_st[2]); end
    checks++; if (done_pc[2] !== 32'h13) begin errors++; $display("FAIL br_bne_pc: got %h want 0013", done_pc[2]); end
    checks++; if (done_st[3] != 5) begin errors++; $display("FAIL br_beq_done_state: got %0d want 5", done_st[3]); end
    checks++; if (u16.r_q[7] !== 16'h0017) begin errors++; $display("FAIL br_beq_target: got %h want 0017", u16.r_q[7]); end
    checks++; if (u16.r_q[1] !== 16'h0000) begin errors++; $display("FAIL br_r1: got %h want 0000", u16.r_q[1]); end
    checks++; if (flags16 !== 3'b011) begin errors++; $display("FAIL br_flags: got %b want 011", flags16); end
  endtask

  task automatic test_alu();
    clear_mems();
    mem16[16] = 16'h1403;  // mv  r2,#3
    mem16[17] = 16'h7405;  // sub r2,#5
    mem16[18] = 16'hD40F;  // and r2,#0x0F
    mem16[19] = 16'h17FF;  // mv  r3,#-1
    mem16[20] = 16'h4403;  // add r2,r3
    reset_dut(1'b0);
    run_prog(1'b0, 2, 40);
    checks++; if (u16.r_q[2] !== 16'hFFFE) begin errors++; $display("FAIL alu_sub_res: got %h want fffe", u16.r_q[2]); end
    checks++; if (flags16 !== 3'b100) begin errors++; $display("FAIL alu_sub_flags: got %b want 100", flags16); end
    run_prog(1'b0, 1, 20);
    checks++; if (u16.r_q[2] !== 16'h000E) begin errors++; $display("FAIL alu_and_res: got %h want 000e", u16.r_q[2]); end
    checks++; if (flags16 !== 3'b000) begin errors++; $display("FAIL alu_and_flags: got %b want 000", flags16); end
    run_prog(1'b0, 2, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL alu_timeout: got %0d done pulses want 2", done_cyc.size()); end
    checks++; if (u16.r_q[2] !== 16'h000D) begin errors++; $display("FAIL alu_addreg_res: got %h want 000d", u16.r_q[2]); end
    checks++; if (flags16 !== 3'b001) begin errors++; $display("FAIL alu_addreg_flags: got %b want 001", flags16); end
  endtask

  task automatic test_st_ld();
    clear_mems();
    mem32[0] = 32'h1640;   // mv  r3,#0x40
    mem32[1] = 32'h34AB;   // mvt r2,#0xAB
    mem32[2] = 32'hA403;   // st  r2,[r3]
    mem32[3] = 32'h8803;   // ld  r4,[r3]
    reset_dut(1'b1);
    run_prog(1'b1, 4, 80);
    checks++; if (timed_out) begin errors++; $display("FAIL stld_timeout: got %0d done pulses want 4", done_cyc.size()); end
    checks++; if (u32.r_q[2] !== 32'hAB000000) begin errors++; $display("FAIL stld_mvt: got %h want ab000000", u32.r_q[2]); end
    checks++; if (w_cnt != 1) begin errors++; $display("FAIL stld_w_cycles: got %0d want 1", w_cnt); end
    checks++; if (w_dout !== 32'hAB000000) begin errors++; $display("FAIL stld_dout: got %h want ab000000", w_dout); end
    checks++; if (w_addr !== 16'h0040) begin errors++; $display("FAIL stld_addr: got %h want 0040", w_addr); end
    checks++; if (done_st[2] != 4) begin errors++; $display("FAIL stld_st_done_state: got %0d want 4", done_st[2]); end
    checks++; if (mem32[8'h40] !== 32'hAB000000) begin errors++; $display("FAIL stld_mem: got %h want ab000000", mem32[8'h40]); end
    checks++; if (u32.r_q[4] !== 32'hAB000000) begin errors++; $display("FAIL stld_ld: got %h want ab000000", u32.r_q[4]); end
  endtask

  task automatic test_reset_mid();
    bit found;
    clear_mems();
    mem16[16] = 16'h1A07;  // mv  r5,#7
    mem16[17] = 16'h1DF9;  // mv  r6,#-7
    mem16[18] = 16'h4A06;  // add r5,r6 -> would give 0, flags 011
    reset_dut(1'b0);
    run_prog(1'b0, 2, 40);
    checks++; if (u16.r_q[5] !== 16'h0007) begin errors++; $display("FAIL mid_pre_r5: got %h want 0007", u16.r_q[5]); end
    found = 1'b0;
    run16 = 1'b1;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      run16 = 1'b0;
      if (st16 === 3'd4) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach_t4: got state %0d want 4", st16); end
    rstn16 = 1'b0;
    @(negedge clk);
    checks++; if (st16 !== 3'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", st16); end
    checks++; if (flags16 !== 3'b000) begin errors++; $display("FAIL mid_flags: got %b want 000", flags16); end
    checks++; if (u16.r_q[7] !== 16'h0010) begin errors++; $display("FAIL mid_pc: got %h want 0010", u16.r_q[7]); end
    rstn16 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (u16.r_q[5] !== 16'h0000) begin errors++; $display("FAIL mid_r5: got %h want 0000", u16.r_q[5]); end
    checks++; if (flags16 !== 3'b000) begin errors++; $display("FAIL mid_flags_after: got %b want 000", flags16); end
    checks++; if (w16 !== 1'b0) begin errors++; $display("FAIL mid_w: got %b want 0", w16); end
  endtask

  task automatic test_shift();
    logic [15:0] exp_r0;
    logic [2:0]  exp_flags;
    int          exp_state;
    clear_mems();
    mem16[16] = 16'h3080;  // mvt r0,#0x80
    mem16[17] = 16'h5001;  // add r0,#1 -> 0x8001, flags 100
    mem16[18] = 16'hF041;  // asr r0,#1 when the shifter is built
`ifdef PROC_SHIFT_EN
    exp_r0 = 16'hC000; exp_flags = 3'b101; exp_state = 5;
`else
    exp_r0 = 16'h8001; exp_flags = 3'b100; exp_state = 3;
`endif
    reset_dut(1'b0);
    run_prog(1'b0, 3, 60);
    checks++; if (timed_out) begin errors++; $display("FAIL shift_timeout: got %0d done pulses want 3", done_cyc.size()); end
    checks++; if (u16.r_q[0] !== exp_r0) begin errors++; $display("FAIL shift_r0: got %h want %h", u16.r_q[0], exp_r0); end
    checks++; if (flags16 !== exp_flags) begin errors++; $display("FAIL shift_flags: got %b want %b", flags16, exp_flags); end
    checks++; if (done_st[2] != exp_state) begin errors++; $display("FAIL shift_done_state: got %0d want %0d", done_st[2], exp_state); end
  endtask

  initial begin
    rstn16 = 1'b0;
    rstn32 = 1'b0;
    run16  = 1'b0;
    run32  = 1'b0;
    @(negedge clk);
    test_reset();
    test_mv_add();
    test_branch();
    test_alu();
    test_st_ld();
    test_reset_mid();
    test_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
